sin_phase_gen: RTL and testbench

- Upstream stimulus stage for the combinational 24-bit sine core.
- Produces a registered stream of 24-bit phase words: start phase + n*step, modulo 2^24.
- Stream uses a valid/ready handshake; a programmable number of samples is emitted per run.
- Replaces file-driven angle stimulus in hardware runs; sine core input is tied to out_phase.

---
 rtl/sin_gen_pkg.sv | 22 ++
 rtl/sin_phase_lfsr.sv | 38 +++
 rtl/sin_phase_gen.sv | 126 ++++++++++++
 tb/tb_sin_phase_gen.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/sin_gen_pkg.sv
// sin_gen_pkg: shared widths, FSM state type and dither LFSR constants for
// the sine-core phase generator.
package sin_gen_pkg;

  localparam int PHASE_W_DEF = 24;
  localparam int CNT_W_DEF   = 17;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } gen_state_t;

  // Taps for x^8+x^6+x^5+x^4+1 as bit positions 7,5,4,3 of a left-shifting register
  localparam logic [7:0] LFSR_SEED = 8'hA5;
  localparam logic [7:0] LFSR_TAPS = 8'b1011_1000;

  function automatic logic [7:0] lfsr_step(input logic [7:0] s);
    return {s[6:0], ^(s & LFSR_TAPS)};
  endfunction

endpackage

// File: rtl/sin_phase_lfsr.sv
// sin_phase_lfsr: 8-bit Fibonacci LFSR supplying a 4-bit phase dither.
// Exposes the value the register is about to take so the parent can register
// its dithered phase in the same cycle.
module sin_phase_lfsr
  import sin_gen_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       load,
  input  logic       advance,
  output logic [3:0] dither_next
);

  logic [7:0] lfsr_q;
  logic [7:0] lfsr_d;

  // Reseed on a new run, otherwise step once per accepted sample
  always_comb begin
    lfsr_d = lfsr_q;
    if (load) begin
      lfsr_d = LFSR_SEED;
    end else if (advance) begin
      lfsr_d = lfsr_step(lfsr_q);
    end
  end

  // LFSR state register, seeded on reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lfsr_q <= LFSR_SEED;
    end else begin
      lfsr_q <= lfsr_d;
    end
  end

  assign dither_next = lfsr_d[3:0];

endmodule

// File: rtl/sin_phase_gen.sv
// sin_phase_gen: emits a valid/ready stream of phase words
// start_phase + n*step (mod 2^PHASE_W) for a programmed number of samples.
// Define SIN_PHASE_DITHER_EN to add a 4-bit LFSR dither to out_phase.
module sin_phase_gen
  import sin_gen_pkg::*;
#(
  parameter int PHASE_W = PHASE_W_DEF,
  parameter int CNT_W   = CNT_W_DEF
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic               abort,
  input  logic [PHASE_W-1:0] cfg_start_phase,
  input  logic [PHASE_W-1:0] cfg_step,
  input  logic [CNT_W-1:0]   cfg_count,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [PHASE_W-1:0] out_phase,
  output logic [CNT_W-1:0]   out_index,
  output logic               busy,
  output logic               done
);

  gen_state_t         state, state_nxt;
  logic [PHASE_W-1:0] acc, acc_d;
  logic [PHASE_W-1:0] step_q;
  logic [CNT_W-1:0]   idx, idx_d;
  logic [CNT_W-1:0]   count_q;
  logic               valid_q;
  logic               done_q;
  logic               start_accept;
  logic               handshake;
  logic               last_sample;

  assign start_accept = (state == IDLE) && start;
  assign handshake    = (state == RUN) && valid_q && out_ready;
  assign last_sample  = (idx == count_q - CNT_W'(1));

  // Next-state logic; start beats abort in IDLE because abort is only looked at in RUN
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (start) begin
          state_nxt = (cfg_count != '0) ? RUN : DONE;
        end
      end
      RUN: begin
        if (abort || (handshake && last_sample)) begin
          state_nxt = DONE;
        end
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Accumulator and index: load on start, advance only on an accepted sample
  always_comb begin
    acc_d = acc;
    idx_d = idx;
    if (start_accept) begin
      acc_d = cfg_start_phase;
      idx_d = '0;
    end else if (handshake) begin
      acc_d = acc + step_q;
      idx_d = idx + CNT_W'(1);
    end
  end

  // State, datapath and flop-driven handshake outputs; done lands one cycle after DONE
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      acc     <= '0;
      idx     <= '0;
      step_q  <= '0;
      count_q <= '0;
      valid_q <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state   <= state_nxt;
      acc     <= acc_d;
      idx     <= idx_d;
      valid_q <= (state_nxt == RUN);
      done_q  <= (state == DONE);
      if (start_accept) begin
        step_q  <= cfg_step;
        count_q <= cfg_count;
      end
    end
  end

`ifdef SIN_PHASE_DITHER_EN
  logic [3:0]         dither_next;
  logic [PHASE_W-1:0] phase_q;

  sin_phase_lfsr u_lfsr (
    .clk         (clk),
    .rst_n       (rst_n),
    .load        (start_accept),
    .advance     (handshake),
    .dither_next (dither_next)
  );

  // Dithered phase register; the accumulator itself stays undithered
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      phase_q <= '0;
    end else begin
      phase_q <= acc_d + PHASE_W'(dither_next);
    end
  end

  assign out_phase = phase_q;
`else
  assign out_phase = acc;
`endif

  assign out_valid = valid_q;
  assign out_index = idx;
  assign busy      = (state == RUN);
  assign done      = done_q;

endmodule

// File: tb/tb_sin_phase_gen.sv
// tb_sin_phase_gen: directed, table-driven bench for sin_phase_gen.
// Works with or without SIN_PHASE_DITHER_EN; expected phases include the
// reference LFSR dither when the macro is defined.
module tb_sin_phase_gen;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic        abort;
  logic [23:0] cfg_start_phase;
  logic [23:0] cfg_step;
  logic [16:0] cfg_count;
  logic        out_valid;
  logic        out_ready;
  logic [23:0] out_phase;
  logic [16:0] out_index;
  logic        busy;
  logic        done;

  int assert_count = 0;
  int fail_count   = 0;

  typedef struct packed {
    logic [23:0]       start_phase;
    logic [23:0]       step;
    logic [16:0]       count;
    logic [0:3][23:0]  exp;
  } vec_t;

  vec_t vecs [4];

  sin_phase_gen dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .start           (start),
    .abort           (abort),
    .cfg_start_phase (cfg_start_phase),
    .cfg_step        (cfg_step),
    .cfg_count       (cfg_count),
    .out_valid       (out_valid),
    .out_ready       (out_ready),
    .out_phase       (out_phase),
    .out_index       (out_index),
    .busy            (busy),
    .done            (done)
  );

  // Free-running 100 MHz clock
  always #5 clk = ~clk;

  // Hard time limit so the bench can never hang
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    assert_count++;
    if (actual !== expected) begin
      fail_count++;
      $display("[TB] FAIL %s: actual=0x%0h required=0x%0h", name, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic s, input logic a, input logic r,
                               input logic [23:0] sp, input logic [23:0] st,
                               input logic [16:0] cnt);
    start           = s;
    abort           = a;
    out_ready       = r;
    cfg_start_phase = sp;
    cfg_step        = st;
    cfg_count       = cnt;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference dither: nibble of the LFSR after n steps from the seed
  function automatic logic [3:0] dith(input int n);
    logic [7:0] s;
    s = 8'hA5;
    for (int i = 0; i < n; i++) s = {s[6:0], s[7] ^ s[5] ^ s[4] ^ s[3]};
`ifdef SIN_PHASE_DITHER_EN
    return s[3:0];
`else
    return 4'h0;
`endif
  endfunction

  function automatic logic [23:0] exp_phase(input logic [23:0] base, input int n);
    return base + {20'h0, dith(n)};
  endfunction

  task automatic checkSample(input string tag, input int n, input logic [23:0] base);
    checkOutput($sformatf("%s valid[%0d]", tag, n), out_valid, 1'b1);
    checkOutput($sformatf("%s phase[%0d]", tag, n), out_phase, exp_phase(base, n));
    checkOutput($sformatf("%s index[%0d]", tag, n), out_index, n);
  endtask

  task automatic checkIdleOutputs(input string tag);
    checkOutput({tag, " valid"}, out_valid, 1'b0);
    checkOutput({tag, " phase"}, out_phase, 24'h0);
    checkOutput({tag, " index"}, out_index, 17'h0);
    checkOutput({tag, " busy"},  busy,      1'b0);
    checkOutput({tag, " done"},  done,      1'b0);
  endtask

  // Directed test sequence
  initial begin
    vecs[0] = '{24'h000000, 24'h000100, 17'd4, {24'h000000, 24'h000100, 24'h000200, 24'h000300}};
    vecs[1] = '{24'hFFFF80, 24'h000100, 17'd3, {24'hFFFF80, 24'h000080, 24'h000180, 24'h000000}};
    vecs[2] = '{24'h000000, 24'h000000, 17'd4, {24'h000000, 24'h000000, 24'h000000, 24'h000000}};
    vecs[3] = '{24'h800000, 24'h7FFFFF, 17'd4, {24'h800000, 24'hFFFFFF, 24'h7FFFFE, 24'hFFFFFD}};

    rst_n = 1'b0;
    applyStimulus(0, 0, 0, 24'h0, 24'h0, 17'd0);
    #2;
    checkIdleOutputs("reset");
    tick();
    tick();
    rst_n = 1'b1;
    tick();

    $display("[TB] table-driven runs with out_ready held high");
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1, 0, 1, vecs[i].start_phase, vecs[i].step, vecs[i].count);
      tick();
      applyStimulus(0, 0, 1, 24'h0, 24'h0, 17'd0);
      for (int s = 0; s < int'(vecs[i].count); s++) begin
        checkSample($sformatf("vec%0d", i), s, vecs[i].exp[s]);
        checkOutput($sformatf("vec%0d busy[%0d]", i, s), busy, 1'b1);
        tick();
      end
      checkOutput($sformatf("vec%0d valid_drop", i), out_valid, 1'b0);
      checkOutput($sformatf("vec%0d done_early", i), done, 1'b0);
      tick();
      checkOutput($sformatf("vec%0d done_pulse", i), done, 1'b1);
      checkOutput($sformatf("vec%0d busy_end", i), busy, 1'b0);
      tick();
      checkOutput($sformatf("vec%0d done_clear", i), done, 1'b0);
    end

    $display("[TB] backpressure on first sample");
    applyStimulus(1, 0, 0, 24'h000010, 24'h000020, 17'd3);
    tick();
    applyStimulus(0, 0, 0, 24'h0, 24'h0, 17'd0);
    for (int k = 0; k < 5; k++) begin
      checkSample($sformatf("bp_hold%0d", k), 0, 24'h000010);
      tick();
    end
    out_ready = 1'b1;
    checkSample("bp", 0, 24'h000010);
    tick();
    checkSample("bp", 1, 24'h000030);
    tick();
    checkSample("bp", 2, 24'h000050);
    tick();
    checkOutput("bp valid_drop", out_valid, 1'b0);
    tick();
    checkOutput("bp done_pulse", done, 1'b1);
    tick();

    $display("[TB] zero-count run");
    applyStimulus(1, 0, 1, 24'h123456, 24'h000010, 17'd0);
    tick();
    applyStimulus(0, 0, 1, 24'h0, 24'h0, 17'd0);
    checkOutput("zero valid1", out_valid, 1'b0);
    checkOutput("zero done1",  done,      1'b0);
    checkOutput("zero busy1",  busy,      1'b0);
    tick();
    checkOutput("zero valid2", out_valid, 1'b0);
    checkOutput("zero done2",  done,      1'b1);
    tick();
    checkOutput("zero done3",  done,      1'b0);

    $display("[TB] start pulsed mid-run is ignored");
    applyStimulus(1, 0, 1, 24'h000000, 24'h000001, 17'd10);
    tick();
    applyStimulus(0, 0, 1, 24'h0, 24'h0, 17'd0);
    for (int s = 0; s < 10; s++) begin
      checkSample("busy_start", s, 24'(s));
      if (s == 3) applyStimulus(1, 0, 1, 24'h500000, 24'h000003, 17'd2);
      else        applyStimulus(0, 0, 1, 24'h0, 24'h0, 17'd0);
      tick();
    end
    checkOutput("busy_start valid_drop", out_valid, 1'b0);
    tick();
    checkOutput("busy_start done_pulse", done, 1'b1);
    tick();
    checkOutput("busy_start no_restart", out_valid, 1'b0);

    $display("[TB] start+abort together, then abort at index 5");
    applyStimulus(1, 1, 1, 24'h001000, 24'h000010, 17'd100000);
    tick();
    applyStimulus(0, 0, 1, 24'h0, 24'h0, 17'd0);
    for (int s = 0; s < 6; s++) begin
      checkSample("abort", s, 24'h001000 + 24'(s * 16));
      if (s == 5) abort = 1'b1;
      tick();
    end
    abort = 1'b0;
    checkOutput("abort valid_drop", out_valid, 1'b0);
    checkOutput("abort busy_drop",  busy,      1'b0);
    tick();
    checkOutput("abort done_pulse", done, 1'b1);
    tick();
    checkOutput("abort done_clear", done, 1'b0);
    checkOutput("abort stays_idle", out_valid, 1'b0);

    $display("[TB] reset asserted mid-run");
    applyStimulus(1, 0, 1, 24'h000000, 24'h000001, 17'd50);
    tick();
    applyStimulus(0, 0, 1, 24'h0, 24'h0, 17'd0);
    tick();
    tick();
    checkOutput("rst_mid index_before", out_index, 17'd2);
    #2;
    rst_n = 1'b0;
    #1;
    checkIdleOutputs("rst_mid");
    tick();
    tick();
    checkOutput("rst_mid done_held", done, 1'b0);
    rst_n = 1'b1;
    tick();
    checkOutput("rst_mid done_after1", done, 1'b0);
    checkOutput("rst_mid valid_after", out_valid, 1'b0);
    tick();
    checkOutput("rst_mid done_after2", done, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", assert_count, fail_count);
    $finish;
  end

endmodule
